// File: rtl/piso_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : piso_ctrl
// Description : Feeds buffered words into an external PISO shifter, frames the
//               serial bits and recaptures them for loop-back comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_ctrl #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             sel,
   output logic [WIDTH-1:0] pin,
   input  logic             sout,
   output logic             frame_valid,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] cap_data,
   output logic             cap_valid,
   output logic             mismatch
);

   localparam int                   c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_cnt_w-1:0]   c_last_bit = c_cnt_w'(WIDTH - 1);
   localparam logic [3:0]           c_gap_last = 4'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_count;
   logic [WIDTH-1:0]   r_mem [2];
   logic [WIDTH-1:0]   r_sent;
   logic [WIDTH-2:0]   r_cap_shift;
   logic [WIDTH-1:0]   r_cap_data;
   logic               r_cap_valid;
   logic               r_mismatch;
   logic [c_cnt_w-1:0] r_bit_cnt;
   logic [3:0]         r_gap_cnt;
   logic               w_push;
   logic               w_pop;
   logic               w_wr_idx;
   logic               w_last_bit;
   logic [WIDTH-1:0]   w_cap_word;

   assign in_ready   = ~rst & (r_count != 2'd2);
   assign w_push     = in_valid & in_ready;
   assign w_pop      = (r_state == S_LOAD);
   // A pop in the same cycle frees slot 0, so the incoming word lands there.
   assign w_wr_idx   = (r_count == 2'd1) & ~w_pop;
   assign w_last_bit = (r_bit_cnt == c_last_bit);
   assign w_cap_word = {r_cap_shift, sout};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= 2'd0;
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else begin
         if (w_pop)
            r_mem[0] <= r_mem[1];
         if (w_push)
            r_mem[w_wr_idx] <= in_data;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_gap_cnt   <= 4'd0;
         r_sent      <= '0;
         r_cap_shift <= '0;
         r_cap_data  <= '0;
         r_cap_valid <= 1'b0;
         r_mismatch  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cap_valid <= 1'b0;
         case (r_state)
            S_LOAD: begin
               r_sent    <= r_mem[0];
               r_bit_cnt <= '0;
            end
            S_SHIFT: begin
               r_cap_shift <= w_cap_word[WIDTH-2:0];
               r_gap_cnt   <= 4'd0;
               if (w_last_bit) begin
                  r_bit_cnt   <= '0;
                  r_cap_data  <= w_cap_word;
                  r_cap_valid <= 1'b1;
                  r_mismatch  <= (w_cap_word != r_sent);
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            S_GAP:   r_gap_cnt <= r_gap_cnt + 4'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      sel         = 1'b1;
      pin         = '0;
      frame_valid = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != 2'd0)
               w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            sel         = 1'b0;
            pin         = r_mem[0];
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            frame_valid = 1'b1;
            done        = w_last_bit;
            if (w_last_bit) begin
               if (GAP > 0)
                  w_state_nxt = S_GAP;
               else
                  w_state_nxt = (r_count != 2'd0) ? S_LOAD : S_IDLE;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == c_gap_last)
               w_state_nxt = (r_count != 2'd0) ? S_LOAD : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign busy      = (r_state != S_IDLE);
   assign cap_data  = r_cap_data;
   assign cap_valid = r_cap_valid;
   assign mismatch  = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_piso_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_ctrl
// Description : Bench for piso_ctrl with an attached PISO shifter and a
//               frame-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_ctrl;

   localparam int           W           = 4;
   localparam int           G           = 1;
   localparam logic [W-1:0] c_flip_mask = W'(4);

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         sel;
   logic [W-1:0] pin;
   logic         sout;
   logic         frame_valid;
   logic         done;
   logic         busy;
   logic [W-1:0] cap_data;
   logic         cap_valid;
   logic         mismatch;

   piso_ctrl #(.WIDTH(W), .GAP(G)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .sel         (sel),
      .pin         (pin),
      .sout        (sout),
      .frame_valid (frame_valid),
      .done        (done),
      .busy        (busy),
      .cap_data    (cap_data),
      .cap_valid   (cap_valid),
      .mismatch    (mismatch)
   );

   always #5 clk = ~clk;

   // External shifter; flip corrupts bit 2 of the word it loads.
   logic [W-1:0] piso_reg = '0;
   logic         flip     = 1'b0;
   always @(posedge clk) begin
      if (sel == 1'b0)
         piso_reg <= pin ^ (flip ? c_flip_mask : '0);
      else
         piso_reg <= {piso_reg[W-2:0], 1'b0};
   end
   assign sout = piso_reg[W-1];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit checking = 1'b0;
   logic [W-1:0] caps[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: each accepted word is a frame with a LOAD cycle; every
   // output is derived from the distance between now and that LOAD cycle.
   typedef struct {
      logic [W-1:0] word;
      int           acc;
      int           ld;
      bit           flip;
   } frame_t;

   frame_t       frq[$];
   int           last_ld = -1000;
   logic [W-1:0] e_cap   = '0;
   bit           e_mis   = 1'b0;

   function automatic int fifo_count(input int c);
      int n = 0;
      foreach (frq[i])
         if (frq[i].acc < c && c <= frq[i].ld) n++;
      return n;
   endfunction

   initial begin : model_and_check
      bit           e_ready, e_sel, e_fv, e_done, e_busy, e_cv;
      logic [W-1:0] e_pin;
      int           ld, nl;
      forever begin
         @(posedge clk);
         if (rst) begin
            frq.delete();
            last_ld = -1000;
            e_cap   = '0;
            e_mis   = 1'b0;
         end else if (in_valid && fifo_count(cyc) < 2) begin
            nl = (cyc + 2 > last_ld + W + 1 + G) ? cyc + 2 : last_ld + W + 1 + G;
            frq.push_back('{in_data, cyc, nl, 1'b0});
            last_ld = nl;
         end
         cyc++;
         while (frq.size() > 0 && frq[0].ld + W + G + 1 < cyc)
            void'(frq.pop_front());

         @(negedge clk);
         e_ready = !rst && fifo_count(cyc) < 2;
         e_sel = 1'b1; e_pin = '0; e_fv = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_cv = 1'b0;
         foreach (frq[i]) begin
            ld = frq[i].ld;
            if (cyc == ld) begin
               e_sel = 1'b0;
               e_pin = frq[i].word;
               frq[i].flip = flip;
            end
            if (cyc > ld && cyc <= ld + W) e_fv = 1'b1;
            if (cyc == ld + W) e_done = 1'b1;
            if (cyc >= ld && cyc <= ld + W + G) e_busy = 1'b1;
            if (cyc == ld + W + 1) begin
               e_cv  = 1'b1;
               e_cap = frq[i].word ^ (frq[i].flip ? c_flip_mask : '0);
               e_mis = frq[i].flip;
            end
         end
         if (checking) begin
            chk("in_ready", in_ready, e_ready);
            chk("sel", sel, e_sel);
            chk("pin", pin, e_pin);
            chk("frame_valid", frame_valid, e_fv);
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            chk("cap_valid", cap_valid, e_cv);
            chk("cap_data", cap_data, e_cap);
            chk("mismatch", mismatch, e_mis);
            if (cap_valid === 1'b1) caps.push_back(cap_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_cycle(input int c);
      int guard = 0;
      while (cyc < c && guard < 1000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int           t, idx, guard, bad;
      bit           acc;
      logic [W-1:0] exp_bits;
      logic [W-1:0] words [4];

      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      repeat (3) tick();
      checking = 1'b1;
      at_cycle(cyc);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_sel", sel, 1);
      chk("rst_pin", pin, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cap_data", cap_data, 0);
      tick();
      rst = 1'b0;
      at_cycle(cyc);
      chk("ready_after_rst", in_ready, 1);
      idle(3);

      // single word
      t = cyc; in_valid = 1'b1; in_data = 4'b1001;
      tick(); in_valid = 1'b0;
      at_cycle(t + 2);
      chk("single_load_sel", sel, 0);
      chk("single_load_pin", pin, 4'b1001);
      exp_bits = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         at_cycle(t + 3 + k);
         chk("single_fv", frame_valid, 1);
         chk("single_sout", sout, exp_bits[3-k]);
         chk("single_done", done, (k == 3));
      end
      at_cycle(t + 7);
      chk("single_cap_valid", cap_valid, 1);
      chk("single_cap_data", cap_data, 4'b1001);
      chk("single_mismatch", mismatch, 0);
      tick(); idle(10);

      // back-to-back
      t = cyc; in_valid = 1'b1; in_data = 4'b1001;
      tick(); in_data = 4'b1100;
      tick(); in_valid = 1'b0;
      at_cycle(t + 2);
      chk("b2b_ready_full", in_ready, 0);
      at_cycle(t + 3);
      chk("b2b_ready_back", in_ready, 1);
      at_cycle(t + 8);
      chk("b2b_load2_sel", sel, 0);
      chk("b2b_load2_pin", pin, 4'b1100);
      exp_bits = 4'b1100;
      for (int k = 0; k < 4; k++) begin
         at_cycle(t + 9 + k);
         chk("b2b_sout", sout, exp_bits[3-k]);
      end
      tick(); idle(10);

      // backpressure
      words[0] = 4'b0011; words[1] = 4'b1010; words[2] = 4'b0110; words[3] = 4'b1111;
      caps.delete();
      idx = 0; guard = 0;
      while (idx < 4 && guard < 60) begin
         in_valid = 1'b1;
         in_data  = words[idx];
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) idx++;
         guard++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", idx, 4);
      chk("bp_stalled", (guard > 4), 1);
      idle(40);
      chk("bp_cap_count", caps.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < caps.size()) chk("bp_cap_order", caps[i], words[i]);

      // reset mid-frame with one word buffered
      caps.delete();
      t = cyc; in_valid = 1'b1; in_data = 4'b0101;
      tick(); in_data = 4'b1110;
      tick(); in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      at_cycle(t + 4);
      chk("rstmid_in_shift", frame_valid, 1);
      chk("rstmid_ready_low", in_ready, 0);
      tick();
      at_cycle(t + 5);
      chk("rstmid_ready_low2", in_ready, 0);
      chk("rstmid_sel", sel, 1);
      chk("rstmid_pin", pin, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_fv", frame_valid, 0);
      tick();
      rst = 1'b0;
      at_cycle(t + 6);
      chk("rstmid_ready_after", in_ready, 1);
      bad = 0;
      for (int k = 6; k < 18; k++) begin
         at_cycle(t + k);
         if (done !== 1'b0 || cap_valid !== 1'b0 || sel !== 1'b1) bad++;
      end
      chk("rstmid_quiet", bad, 0);
      chk("rstmid_no_caps", caps.size(), 0);
      tick(); idle(3);

      // mismatch
      flip = 1'b1;
      t = cyc; in_valid = 1'b1; in_data = 4'b1001;
      tick(); in_valid = 1'b0;
      at_cycle(t + 7);
      chk("mis_cap_valid", cap_valid, 1);
      chk("mis_cap_data", cap_data, 4'b1101);
      chk("mis_flag", mismatch, 1);
      tick(); flip = 1'b0; idle(10);

      // randomized traffic with occasional resets and corruption
      for (int n = 0; n < 3000; n++) begin
         tick();
         in_valid = ($urandom_range(0, 99) < 45);
         in_data  = W'($urandom);
         if (rst) rst = ($urandom_range(0, 1) == 0);
         else     rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) flip = ~flip;
      end
      tick();
      rst = 1'b0; flip = 1'b0;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piso_ctrl.md
PISO_CTRL -- requirements
Module: piso_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: PISO word width in bits; legal range 2-16.
REQ-002 Parameter GAP, default 1: idle cycles between consecutive frames; legal range 0-15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 in_ready  output  1  controller can accept a word; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-008 sel  output  1  PISO mode: 0 = parallel load, 1 = shift.
REQ-009 pin  output  WIDTH  PISO parallel input.
REQ-010 sout  input  1  PISO serial output, MSB first.
REQ-011 frame_valid  output  1  high while sout carries a valid frame bit.
REQ-012 done  output  1  one-cycle pulse on the last bit of a frame.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 cap_data  output  WIDTH  word reconstructed from sout.
REQ-015 cap_valid  output  1  one-cycle pulse; cap_data and mismatch are valid.
REQ-016 mismatch  output  1  cap_data differs from the word that was loaded; updated only with cap_valid.

Function
REQ-017 Buffer: 2-entry FIFO; in_ready = (count < 2), forced 0 while rst=1.
- Push on a handshake; pop at the end of the LOAD cycle.
- Simultaneous push and pop at count 1 leaves count at 1.
- No push occurs at count 2.
REQ-018 State machine has four states: IDLE, LOAD, SHIFT, GAP.
REQ-019 IDLE: sel=1, pin=0; go to LOAD when count > 0, else remain in IDLE.
REQ-020 LOAD lasts exactly one cycle:
- sel=0 and pin = FIFO head for the whole cycle.
- Head is copied to an internal sent register.
- FIFO pops; bit_cnt is cleared; next state is SHIFT.
REQ-021 SHIFT lasts exactly WIDTH cycles:
- sel=1, frame_valid=1, pin=0.
- Each cycle, sout is shifted into the capture register LSB.
- bit_cnt increments each cycle.
- done=1 in the cycle where bit_cnt = WIDTH-1.
REQ-022 Exit from SHIFT after the last bit:
- GAP > 0: go to GAP.
- GAP = 0: go to LOAD if count > 0, else IDLE.
REQ-023 GAP: sel=1; hold for GAP cycles, then go to LOAD if count > 0, else IDLE.
REQ-024 Capture result, registered in the cycle after the last SHIFT cycle:
- cap_valid pulses.
- cap_data = captured word.
- mismatch = (captured word != sent).
REQ-025 Latency: a handshake at cycle t while IDLE with an empty FIFO gives LOAD at t+2 and first frame bit at t+3.
REQ-026 Back-to-back frame spacing is WIDTH+1+GAP cycles, measured first bit to first bit.
REQ-027 done, cap_valid and frame_valid never assert outside the rules above; bit_cnt never exceeds WIDTH-1.

Reset
REQ-028 While rst=1 at a rising edge, the next state is:
- State IDLE; FIFO emptied; bit_cnt=0; GAP counter=0.
- sel=1, pin=0.
- frame_valid=0, done=0, busy=0.
- cap_data=0, cap_valid=0, mismatch=0.
REQ-029 Reset mid-frame:
- The frame is abandoned.
- No done or cap_valid is produced for it.
- Buffered words are discarded.
REQ-030 in_ready=0 during rst; in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-031 Reset: rst=1 for 2 cycles mid-stream -> sel=1, pin=0, busy=0, in_ready=0 during reset; in_ready=1 on the first cycle after.
REQ-032 Single word: push 4'b1001 at t into a bench PISO model.
- LOAD at t+2 with sel=0, pin=1001.
- frame_valid t+3..t+6 with sout 1,0,0,1.
- done at t+6.
- cap_valid at t+7 with cap_data=1001, mismatch=0.
REQ-033 Back-to-back, GAP=1: push 1001 at t, 1100 at t+1.
- in_ready=0 at t+2, back to 1 at t+3.
- Second LOAD at t+8 with pin=1100.
- Second frame bits t+9..t+12: 1,1,0,0.
REQ-034 Backpressure: in_valid held for 4 words from t, t+1, t+2, t+3.
- Third word stalls until in_ready returns.
- All four frames emerge in order, no loss or duplication.
REQ-035 Reset mid-frame: rst=1 during the 2nd SHIFT cycle with 1 word still buffered.
- Next cycle IDLE with frame_valid=0.
- No done or cap_valid.
- No further LOAD without new pushes.
REQ-036 Mismatch: bench PISO inverts bit 2 of 1001 -> cap_data=1101, mismatch=1 with cap_valid.
